comm_uart_core: RTL and testbench

// - Host link for the mining pipeline: 8N1 UART receiver and transmitter in one clock domain.
// - RX: assembles 44-byte work packets into midstate (256b) plus block tail (96b), then pulses tx_new_work.
// - TX: sends each 32-bit golden-ticket nonce to the host as 4 UART bytes.

---
 rtl/comm_uart_pkg.sv | 27 ++
 rtl/comm_uart_if.sv | 27 ++
 rtl/comm_uart_rx_byte.sv | 101 ++++++++++
 rtl/comm_uart_core.sv | 203 ++++++++++++++++++++
 tb/tb_comm_uart_core.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/comm_uart_pkg.sv
// comm_uart_pkg: shared constants and FSM encodings for the
// host UART link (RX byte engine, packet assembler, ticket sender).
package comm_uart_pkg;

    localparam int WORK_BYTES        = 44;
    localparam int TICKET_BYTES      = 4;
    localparam int GOLDEN_FIFO_DEPTH = 8;
    localparam int WORK_BITS         = WORK_BYTES * 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SEND
    } tx_state_t;

    function automatic int bit_clks(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/comm_uart_if.sv
// comm_uart_if: pipeline-side bundle of the host link
// (ticket strobe in, new work out).
interface comm_uart_if;

    logic         rx_new_golden_ticket;
    logic [31:0]  rx_golden_ticket;
    logic         tx_new_work;
    logic [255:0] tx_midstate;
    logic [95:0]  tx_blockdata;

    modport master (
        output rx_new_golden_ticket,
        output rx_golden_ticket,
        input  tx_new_work,
        input  tx_midstate,
        input  tx_blockdata
    );

    modport slave (
        input  rx_new_golden_ticket,
        input  rx_golden_ticket,
        output tx_new_work,
        output tx_midstate,
        output tx_blockdata
    );

endinterface

// File: rtl/comm_uart_rx_byte.sv
// comm_uart_rx_byte: 8N1 receiver, 2-flop synchroniser plus
// start/data/stop FSM sampling at bit centres.
module comm_uart_rx_byte
    import comm_uart_pkg::*;
#(
    parameter int BIT_CLKS = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(BIT_CLKS + 1);
    localparam logic [TW-1:0] LAST = TW'(BIT_CLKS - 1);
    localparam logic [TW-1:0] HALF = TW'(BIT_CLKS / 2 - 1);

    rx_state_t     state;
    logic [2:0]    sync;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          line;
    logic          fall;

    // sync[1:0] is the synchroniser, sync[2] the previous sample
    assign line = sync[1];
    assign fall = sync[2] & ~sync[1];
    assign busy = (state != RX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 3'b111;
        end else begin
            sync <= {sync[1:0], rx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (fall) begin
                        state <= RX_START;
                        timer <= '0;
                    end
                end
                RX_START: begin
                    if (timer == HALF) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        state   <= line ? RX_IDLE : RX_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (timer == LAST) begin
                        timer   <= '0;
                        shift   <= {line, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (timer == LAST) begin
                        timer <= '0;
                        state <= RX_IDLE;
                        if (line) begin
                            data  <= shift;
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/comm_uart_core.sv
// comm_uart_core: host UART link, work packet assembly and ticket TX.
// Define GOLDEN_FIFO_EN for an 8-deep ticket FIFO instead of one slot.
module comm_uart_core
    import comm_uart_pkg::*;
#(
    parameter int comm_clk_frequency = 100000000,
    parameter int baud_rate          = 115200,
    parameter int rx_timeout_bits    = 100
) (
    input  logic       comm_clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    comm_uart_if.slave bus
);

    localparam int BIT_CLKS = bit_clks(comm_clk_frequency, baud_rate);
    localparam int TW       = $clog2(BIT_CLKS + 1);
    localparam int TO_CLKS  = rx_timeout_bits * BIT_CLKS;
    localparam int TOW      = $clog2(TO_CLKS + 1);

    localparam logic [TW-1:0]  LAST      = TW'(BIT_CLKS - 1);
    localparam logic [TOW-1:0] TO_LAST   = TOW'(TO_CLKS - 1);
    localparam logic [5:0]     LAST_WORK = 6'(WORK_BYTES - 1);
    localparam logic [1:0]     LAST_BYTE = 2'(TICKET_BYTES - 1);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    comm_uart_rx_byte #(
        .BIT_CLKS (BIT_CLKS)
    ) u_rx (
        .clk       (comm_clk),
        .rst_n     (reset_n),
        .rx        (uart_rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_frame_err),
        .busy      (rx_busy)
    );

    logic [WORK_BITS-1:0] work;
    logic [5:0]           byte_cnt;
    logic [TOW-1:0]       idle_cnt;
    logic                 done;

    always_ff @(posedge comm_clk or negedge reset_n) begin
        if (!reset_n) begin
            work     <= '0;
            byte_cnt <= '0;
            idle_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (rx_frame_err) begin
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else if (rx_valid) begin
                work     <= {work[WORK_BITS-9:0], rx_data};
                idle_cnt <= '0;
                if (byte_cnt == LAST_WORK) begin
                    byte_cnt <= '0;
                    done     <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (rx_busy || byte_cnt == '0) begin
                idle_cnt <= '0;
            end else if (idle_cnt == TO_LAST) begin
                // host went quiet mid-packet: drop the partial work
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge comm_clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.tx_new_work  <= 1'b0;
            bus.tx_midstate  <= '0;
            bus.tx_blockdata <= '0;
        end else begin
            bus.tx_new_work <= done;
            if (done) begin
                bus.tx_midstate  <= work[WORK_BITS-1:96];
                bus.tx_blockdata <= work[95:0];
            end
        end
    end

    tx_state_t     tx_state;
    logic          avail;
    logic [31:0]   head;
    logic          take;

    assign take = (tx_state == TX_IDLE) && avail;

`ifdef GOLDEN_FIFO_EN
    localparam int PW = $clog2(GOLDEN_FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fifo [GOLDEN_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          push;
    logic          pop;

    // an idle sender with an empty FIFO takes the strobe directly
    assign empty = (count == '0);
    assign avail = !empty || bus.rx_new_golden_ticket;
    assign head  = empty ? bus.rx_golden_ticket : fifo[rd_ptr];
    assign pop   = take && !empty;
    assign push  = bus.rx_new_golden_ticket && !(take && empty)
                   && (count != CW'(GOLDEN_FIFO_DEPTH));

    always_ff @(posedge comm_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < GOLDEN_FIFO_DEPTH; i++) begin
                fifo[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= bus.rx_golden_ticket;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end
`else
    assign avail = bus.rx_new_golden_ticket;
    assign head  = bus.rx_golden_ticket;
`endif

    logic [TW-1:0] tx_timer;
    logic [3:0]    tx_bit;
    logic [1:0]    tx_byte;
    logic [9:0]    frame;
    logic [31:0]   word;

    always_ff @(posedge comm_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            uart_tx  <= 1'b1;
            tx_timer <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            frame    <= '1;
            word     <= '0;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    if (take) begin
                        word     <= head;
                        tx_state <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    frame    <= {1'b1, word[7:0], 1'b0};
                    word     <= {8'h00, word[31:8]};
                    uart_tx  <= 1'b0;
                    tx_timer <= '0;
                    tx_bit   <= '0;
                    tx_byte  <= '0;
                    tx_state <= TX_SEND;
                end
                TX_SEND: begin
                    if (tx_timer != LAST) begin
                        tx_timer <= tx_timer + 1'b1;
                    end else begin
                        tx_timer <= '0;
                        if (tx_bit != 4'd9) begin
                            frame   <= {1'b0, frame[9:1]};
                            uart_tx <= frame[1];
                            tx_bit  <= tx_bit + 1'b1;
                        end else if (tx_byte == LAST_BYTE) begin
                            tx_state <= TX_IDLE;
                        end else begin
                            frame   <= {1'b1, word[7:0], 1'b0};
                            word    <= {8'h00, word[31:8]};
                            uart_tx <= 1'b0;
                            tx_bit  <= '0;
                            tx_byte <= tx_byte + 1'b1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comm_uart_core.sv
// tb_comm_uart_core: random RX packets and tickets against a
// timestamp-level model, checked by scoreboard monitors.
module tb_comm_uart_core;
    import comm_uart_pkg::*;

    localparam int FREQ      = 800;
    localparam int BAUD      = 100;
    localparam int BIT       = FREQ / BAUD;
    localparam int TOUT_BITS = 100;
    localparam int TKT_CLKS  = 40 * BIT;

    typedef struct {
        logic [7:0] val;
        int         start;
    } txb_t;

    typedef struct {
        logic [255:0] ms;
        logic [95:0]  bd;
    } work_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic tx;
    int   cyc     = 0;
    int   nchecks = 0;
    int   nerrors = 0;

    txb_t       exp_tx[$];
    work_t      exp_work[$];
    logic [7:0] pkt[$];
    int         pend_pop[$];
    work_t      last_work;
    int         last_s    = 0;
    bit         have_last = 1'b0;

    comm_uart_if bus();

    comm_uart_core #(
        .comm_clk_frequency (FREQ),
        .baud_rate          (BAUD),
        .rx_timeout_bits    (TOUT_BITS)
    ) dut (
        .comm_clk (clk),
        .reset_n  (rst_n),
        .uart_rx  (rx),
        .uart_tx  (tx),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] req);
        nchecks++;
        if (act !== req) begin
            nerrors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic wait_bits(input int n);
        if (n > 0) begin
            repeat (n * BIT) @(posedge clk);
            #1;
        end
    endtask

    // packet model: 44 accepted bytes in order, first byte most significant
    task automatic model_byte(input logic [7:0] b);
        work_t w;
        pkt.push_back(b);
        if (pkt.size() == WORK_BYTES) begin
            w.ms = '0;
            w.bd = '0;
            for (int i = 0; i < 32; i++) w.ms = {w.ms[247:0], pkt[i]};
            for (int i = 32; i < 44; i++) w.bd = {w.bd[87:0], pkt[i]};
            exp_work.push_back(w);
            last_work = w;
            pkt.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        if (good) model_byte(b);
        else pkt.delete();
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bits(1);
        end
        rx = good;
        wait_bits(1);
        rx = 1'b1;
        if (!good) wait_bits(1);
    endtask

    task automatic idle_bits(input int n);
        wait_bits(n);
        if (n > TOUT_BITS) pkt.delete();
    endtask

    // ticket model: start-bit times from acceptance rules; caller sits 1ns after posedge
    task automatic issue_ticket(input logic [31:0] t);
        int   k;
        int   s;
        bit   acc;
        txb_t e;
        k = cyc;
        bus.rx_new_golden_ticket = 1'b1;
        bus.rx_golden_ticket     = t;
        s = k + 2;
`ifdef GOLDEN_FIFO_EN
        while (pend_pop.size() > 0 && pend_pop[0] < k) void'(pend_pop.pop_front());
        acc = (pend_pop.size() < GOLDEN_FIFO_DEPTH);
        if (acc && have_last && (last_s + TKT_CLKS + 2 > s)) s = last_s + TKT_CLKS + 2;
        if (acc && (s - 2 != k)) pend_pop.push_back(s - 2);
`else
        acc = !have_last || (k >= last_s + TKT_CLKS);
`endif
        if (acc) begin
            last_s    = s;
            have_last = 1'b1;
            for (int i = 0; i < TICKET_BYTES; i++) begin
                e.val   = t[8*i +: 8];
                e.start = s + i * 10 * BIT;
                exp_tx.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        bus.rx_new_golden_ticket = 1'b0;
    endtask

    initial begin : work_mon
        work_t w;
        forever begin
            @(negedge clk);
            if (rst_n && bus.tx_new_work === 1'b1) begin
                if (exp_work.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL work_unexpected: got pulse at cycle %0d, want none", cyc);
                end else begin
                    w = exp_work.pop_front();
                    chk("midstate", bus.tx_midstate, w.ms);
                    chk("blockdata", {160'b0, bus.tx_blockdata}, {160'b0, w.bd});
                end
            end
        end
    end

    initial begin : tx_mon
        logic [7:0] b;
        logic       stop;
        int         t0;
        txb_t       e;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                t0 = cyc;
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                stop = tx;
                chk("tx_stop", {255'b0, stop}, 256'd1);
                if (exp_tx.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL tx_unexpected: got byte %h, want none", b);
                end else begin
                    e = exp_tx.pop_front();
                    chk("tx_byte", {248'b0, b}, {248'b0, e.val});
                    chk("tx_start_cycle", t0, e.start);
                end
            end
        end
    end

    initial begin : main
        bus.rx_new_golden_ticket = 1'b0;
        bus.rx_golden_ticket     = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_uart_tx", {255'b0, tx}, 256'd1);
        chk("reset_new_work", {255'b0, bus.tx_new_work}, 256'd0);
        chk("reset_midstate", bus.tx_midstate, 256'd0);
        chk("reset_blockdata", {160'b0, bus.tx_blockdata}, 256'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_bits(1);

        for (int i = 0; i < 44; i++) send_byte(8'(i), 1'b1);
        wait_bits(4);
        issue_ticket(32'hA41F32E7);
        wait_bits(45);

        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1);
        send_byte(8'h5A, 1'b0);
        for (int i = 0; i < 44; i++) send_byte(8'($urandom), 1'b1);
        wait_bits(4);

        for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b1);
        idle_bits(120);
        for (int i = 0; i < 44; i++) send_byte(8'(8'hA0 + i), 1'b1);
        wait_bits(4);

        issue_ticket(32'd1);
        issue_ticket(32'd2);
        issue_ticket(32'd3);
        wait_bits(140);

        for (int i = 0; i < 10; i++) issue_ticket(32'h100 + i);
        wait_bits(380);

        fork
            begin
                for (int p = 0; p < 2; p++) begin
                    for (int i = 0; i < 44; i++) begin
                        send_byte(8'($urandom), 1'b1);
                        idle_bits($urandom_range(0, 2));
                    end
                end
            end
            begin
                for (int n = 0; n < 8; n++) begin
                    repeat ($urandom_range(0, 30 * BIT)) @(posedge clk);
                    #1;
                    issue_ticket($urandom);
                end
            end
        join

        for (int i = 0; i < 8000; i++) begin
            if (exp_work.size() == 0 && exp_tx.size() == 0) break;
            @(posedge clk);
        end
        wait_bits(50);
        chk("work_queue_empty", exp_work.size(), 0);
        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("hold_midstate", bus.tx_midstate, last_work.ms);
        chk("hold_blockdata", {160'b0, bus.tx_blockdata}, {160'b0, last_work.bd});
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
